// File: rtl/xif_core_offloader_if.sv
//------------------------------------------------------------------------------
// xif_core_offloader_if : XIF issue/commit/memory/result bundle between core and coprocessor
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface xif_core_offloader_if #(
  parameter int XLEN       = 32,
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2
);
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  logic [31:0]                  issue_instr_o;
  logic [X_ID_WIDTH-1:0]        issue_id_o;
  logic [X_NUM_RS*XLEN-1:0]     issue_rs_o;
  logic [X_NUM_RS-1:0]          issue_rs_valid_o;
  logic                         issue_accept_i;

  logic                         commit_valid_o;
  logic [X_ID_WIDTH-1:0]        commit_id_o;
  logic                         commit_kill_o;

  logic                         mem_valid_i;
  logic                         mem_ready_o;
  logic [X_ID_WIDTH-1:0]        mem_id_i;
  logic [XLEN-1:0]              mem_addr_i;
  logic                         mem_we_i;
  logic [XLEN-1:0]              mem_wdata_i;
  logic                         mem_result_valid_o;
  logic [X_ID_WIDTH-1:0]        mem_result_id_o;
  logic [XLEN-1:0]              mem_result_rdata_o;
  logic                         mem_result_err_o;

  logic                         result_valid_i;
  logic                         result_ready_o;
  logic [X_ID_WIDTH-1:0]        result_id_i;
  logic                         result_we_i;
  logic [4:0]                   result_rd_i;
  logic [XLEN-1:0]              result_data_i;

  modport master (
    output issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
    input  issue_ready_i, issue_accept_i,
    output commit_valid_o, commit_id_o, commit_kill_o,
    input  mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_wdata_i,
    output mem_ready_o, mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    input  result_valid_i, result_id_i, result_we_i, result_rd_i, result_data_i,
    output result_ready_o
  );

  modport slave (
    input  issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
    output issue_ready_i, issue_accept_i,
    input  commit_valid_o, commit_id_o, commit_kill_o,
    output mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_wdata_i,
    input  mem_ready_o, mem_result_valid_o, mem_result_id_o, mem_result_rdata_o, mem_result_err_o,
    output result_valid_i, result_id_i, result_we_i, result_rd_i, result_data_i,
    input  result_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/xif_core_offloader.sv
//------------------------------------------------------------------------------
// xif_core_offloader : XIF initiator with issue/commit sequencing, scratchpad memory and writeback
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xif_core_offloader #(
  parameter int XLEN            = 32,
  parameter int X_ID_WIDTH      = 4,
  parameter int X_NUM_RS        = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_WORDS       = 16,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [X_NUM_RS*XLEN-1:0] rs_i,
  xif_core_offloader_if.master     xif,
  output logic                     wb_valid_o,
  output logic [4:0]               wb_rd_o,
  output logic [XLEN-1:0]          wb_data_o,
  output logic                     reject_o,
  output logic [OW-1:0]            outstanding_o,
  output logic                     protocol_err_o
);
  localparam int              AW        = $clog2(MEM_WORDS);
  localparam logic [OW-1:0]   MAX_CNT   = OW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * MEM_WORDS);

  logic                     hold_q, hold_d;
  logic [31:0]              instr_q, instr_d;
  logic [X_NUM_RS*XLEN-1:0] rs_q, rs_d;
  logic                     commit_pend_q, commit_pend_d;
  logic                     commit_kill_q, commit_kill_d;
  logic [X_ID_WIDTH-1:0]    commit_id_q, commit_id_d;
  logic [X_ID_WIDTH-1:0]    id_q, id_d;
  logic [OW-1:0]            cnt_q, cnt_d;
  logic                     perr_q, perr_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [4:0]               wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;
  logic                     mres_pend_q, mres_pend_d;
  logic [X_ID_WIDTH-1:0]    mres_id_q, mres_id_d;
  logic [XLEN-1:0]          mres_rdata_q, mres_rdata_d;
  logic                     mres_err_q, mres_err_d;
  logic [XLEN-1:0]          mem_q [MEM_WORDS];

  logic          issue_valid, issue_hs, instr_hs, mem_hs, mem_err, inc, res;
  logic [AW-1:0] mem_idx;
  logic          unused_result_id;

  assign instr_ready_o = ~hold_q;
  assign instr_hs      = instr_valid_i & ~hold_q;
  assign issue_valid   = hold_q & ~commit_pend_q & (cnt_q < MAX_CNT);
  assign issue_hs      = issue_valid & xif.issue_ready_i;
  assign inc           = issue_hs & xif.issue_accept_i;
  assign res           = xif.result_valid_i;
  assign mem_hs        = xif.mem_valid_i & ~mres_pend_q;
  assign mem_idx       = xif.mem_addr_i[2 +: AW];
  assign mem_err       = (xif.mem_addr_i[1:0] != 2'b00) | (xif.mem_addr_i >= MEM_BYTES);
  assign unused_result_id = ^xif.result_id_i;

  assign xif.issue_valid_o      = issue_valid;
  assign xif.issue_instr_o      = instr_q;
  assign xif.issue_id_o         = id_q;
  assign xif.issue_rs_o         = rs_q;
  assign xif.issue_rs_valid_o   = '1;
  assign xif.commit_valid_o     = commit_pend_q;
  assign xif.commit_id_o        = commit_id_q;
  assign xif.commit_kill_o      = commit_kill_q;
  assign xif.mem_ready_o        = ~mres_pend_q;
  assign xif.mem_result_valid_o = mres_pend_q;
  assign xif.mem_result_id_o    = mres_id_q;
  assign xif.mem_result_rdata_o = mres_rdata_q;
  assign xif.mem_result_err_o   = mres_err_q;
  assign xif.result_ready_o     = 1'b1;
  assign wb_valid_o             = wb_valid_q;
  assign wb_rd_o                = wb_rd_q;
  assign wb_data_o              = wb_data_q;
  assign reject_o               = commit_pend_q & commit_kill_q;
  assign outstanding_o          = cnt_q;
  assign protocol_err_o         = perr_q;

  always_comb begin
    hold_d        = hold_q;
    instr_d       = instr_q;
    rs_d          = rs_q;
    commit_pend_d = issue_hs;
    commit_id_d   = commit_id_q;
    commit_kill_d = commit_kill_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    perr_d        = perr_q | (res & (cnt_q == '0));
    wb_valid_d    = res & xif.result_we_i & (xif.result_rd_i != 5'd0);
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    mres_pend_d   = mem_hs;
    mres_id_d     = mres_id_q;
    mres_err_d    = 1'b0;
    mres_rdata_d  = '0;

    if (instr_hs) begin
      hold_d  = 1'b1;
      instr_d = instr_i;
      rs_d    = rs_i;
    end
    if (issue_hs) begin
      hold_d        = 1'b0;
      commit_id_d   = id_q;
      commit_kill_d = ~xif.issue_accept_i;
      id_d          = id_q + X_ID_WIDTH'(1);
    end
    // A result with nothing in flight leaves the count pinned at zero.
    if (inc & ~res)
      cnt_d = cnt_q + OW'(1);
    else if (~inc & res & (cnt_q != '0))
      cnt_d = cnt_q - OW'(1);
    if (wb_valid_d) begin
      wb_rd_d   = xif.result_rd_i;
      wb_data_d = xif.result_data_i;
    end
    if (mem_hs) begin
      mres_id_d  = xif.mem_id_i;
      mres_err_d = mem_err;
      if (~xif.mem_we_i & ~mem_err)
        mres_rdata_d = mem_q[mem_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q        <= 1'b0;
      instr_q       <= '0;
      rs_q          <= '0;
      commit_pend_q <= 1'b0;
      commit_id_q   <= '0;
      commit_kill_q <= 1'b0;
      id_q          <= '0;
      cnt_q         <= '0;
      perr_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      mres_pend_q   <= 1'b0;
      mres_id_q     <= '0;
      mres_rdata_q  <= '0;
      mres_err_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      instr_q       <= instr_d;
      rs_q          <= rs_d;
      commit_pend_q <= commit_pend_d;
      commit_id_q   <= commit_id_d;
      commit_kill_q <= commit_kill_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      perr_q        <= perr_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      mres_pend_q   <= mres_pend_d;
      mres_id_q     <= mres_id_d;
      mres_rdata_q  <= mres_rdata_d;
      mres_err_q    <= mres_err_d;
    end
  end

  // Scratchpad contents survive reset; only the write strobe is gated.
  always_ff @(posedge clk_i) begin
    if (~rst_i & mem_hs & xif.mem_we_i & ~mem_err)
      mem_q[mem_idx] <= xif.mem_wdata_i;
  end

endmodule

`default_nettype wire
